branch_resolver_v3: RTL

Parametrised successor to the decode-stage branch resolver. It resolves RV32I conditional branches, JAL and JALR, and computes the redirect target and link address. It also holds a PC-indexed table of 2-bit saturating direction counters: fetch reads it combinationally, and the table is trained on every resolved conditional branch. Mispredict/redirect and performance counts go to the PC unit and the CSR block.

---
 rtl/branch_resolver_v3.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/branch_resolver_v3.sv
// Branch resolver for RV32I conditional branches, JAL and JALR.
// Computes direction, redirect target and link address, trains a PC-indexed
// table of 2-bit saturating direction counters read combinationally by fetch,
// and keeps saturating counts of resolved conditional branches and mispredicts.
// PIPE=0 presents results in the issue cycle; PIPE=1 adds one stage register.
module branch_resolver_v3 #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int PIPE      = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] f_pc,
  output logic            f_pred_taken,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic            in_pred_taken,
  input  logic            flush,
  output logic            res_valid,
  output logic            res_taken,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] link_pc,
  output logic            illegal,
  output logic [31:0]     br_cnt,
  output logic [31:0]     mp_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // One resolved control transfer; cond marks a legal conditional branch,
  // the only kind that trains the table and bumps the counters.
  typedef struct packed {
    logic             valid;
    logic             taken;
    logic             redirect;
    logic             illegal;
    logic             cond;
    logic [XLEN-1:0]  redirect_pc;
    logic [XLEN-1:0]  link_pc;
    logic [IDX_W-1:0] idx;
  } res_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_b, imm_j;
  logic [XLEN-1:0] seq_pc, br_target, jal_target, jalr_sum;
  logic            eq, lt, ltu;

  res_t issue, staged, out;
  logic [1:0]      bht [BHT_DEPTH];
  logic [XLEN-1:0] hold_rpc, hold_lpc;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_b  = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_j  = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};

  assign seq_pc     = in_pc + XLEN'(4);
  assign br_target  = in_pc + imm_b;
  assign jal_target = in_pc + imm_j;
  assign jalr_sum   = in_rs1 + imm_i;

  assign eq  = (in_rs1 == in_rs2);
  assign lt  = ($signed(in_rs1) < $signed(in_rs2));
  assign ltu = (in_rs1 < in_rs2);

  // Decode and resolve the incoming instruction; reset and flush squash it.
  always_comb begin
    // NOTE: the whole struct gets a default first so no path leaves a field
    // unassigned, which would otherwise infer a latch.
    issue = '0;
    if (in_valid && !rst && !flush) begin
      unique case (opcode)
        OP_BRANCH: begin
          issue.valid   = 1'b1;
          issue.link_pc = seq_pc;
          issue.idx     = in_pc[IDX_W+1:2];
          unique case (funct3)
            3'b000:  issue.taken = eq;
            3'b001:  issue.taken = !eq;
            3'b100:  issue.taken = lt;
            3'b101:  issue.taken = !lt;
            3'b110:  issue.taken = ltu;
            3'b111:  issue.taken = !ltu;
            default: issue.illegal = 1'b1;
          endcase
          issue.cond        = !issue.illegal;
          issue.redirect    = issue.cond && (issue.taken != in_pred_taken);
          issue.redirect_pc = issue.taken ? br_target : seq_pc;
        end
        OP_JAL: begin
          issue.valid       = 1'b1;
          issue.taken       = 1'b1;
          issue.redirect    = 1'b1;
          issue.redirect_pc = jal_target;
          issue.link_pc     = seq_pc;
        end
        OP_JALR: begin
          issue.valid       = 1'b1;
          issue.taken       = 1'b1;
          issue.redirect    = 1'b1;
          issue.redirect_pc = {jalr_sum[XLEN-1:1], 1'b0};
          issue.link_pc     = seq_pc;
        end
        default: ;
      endcase
    end
  end

  if (PIPE != 0) begin : g_pipe
    res_t stage;
    // Stage register: one result per cycle, cleared by reset, empty after flush.
    always_ff @(posedge clk) begin
      if (rst) stage <= '0;
      else     stage <= issue;
    end
    assign staged = stage;
  end else begin : g_comb
    assign staged = issue;
  end

  // Flush also kills whatever result is being presented this cycle.
  assign out = flush ? '0 : staged;

  assign res_valid    = out.valid;
  assign res_taken    = out.taken;
  assign redirect     = out.redirect;
  assign illegal      = out.illegal;
  assign redirect_pc  = out.valid ? out.redirect_pc : hold_rpc;
  assign link_pc      = out.valid ? out.link_pc     : hold_lpc;
  assign f_pred_taken = bht[f_pc[IDX_W+1:2]][1];

  // Predictor training at the edge that ends the output cycle; no read bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the table is built from flops, not a RAM macro, so every entry
      // can be returned to weakly-not-taken in the same reset edge.
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (out.valid && out.cond) begin
      if (out.taken) begin
        if (bht[out.idx] != 2'b11) bht[out.idx] <= bht[out.idx] + 2'b01;
      end else begin
        if (bht[out.idx] != 2'b00) bht[out.idx] <= bht[out.idx] - 2'b01;
      end
    end
  end

  // Saturating performance counters, counted in the output cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else if (out.valid && out.cond) begin
      if (br_cnt != '1)                 br_cnt <= br_cnt + 32'd1;
      if (out.redirect && mp_cnt != '1) mp_cnt <= mp_cnt + 32'd1;
    end
  end

  // Last presented addresses, shown while no result is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_rpc <= '0;
      hold_lpc <= '0;
    end else if (out.valid) begin
      hold_rpc <= out.redirect_pc;
      hold_lpc <= out.link_pc;
    end
  end

endmodule
